// File: rtl/cpu_pkg.sv
// Shared definitions for the five-stage RV32I-subset core.
// Contents:
//   - opcode / funct3 / funct7 encodings for ADD, SUB, ADDI, BEQ, BNE
//   - alu_op_e: the two ALU operations
//   - pipeline register structs if_id_t, id_ex_t, ex_mem_t, mem_wb_t,
//     each carrying instr and pc alongside control/data for debug
//   - NOP constants used at reset and for bubbles/flushes
package cpu_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_ADDI    = 3'b000;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    // All-zero word: not a legal encoding of any supported instruction.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        ALU_ADD = 1'b0,
        ALU_SUB = 1'b1
    } alu_op_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        we;        // writes rd (already excludes rd == x0)
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;       // I-type for ADDI, B-type for branches
        logic        use_imm;
        alu_op_e     alu_op;
        logic        is_branch;
        logic        br_ne;     // 1: BNE, 0: BEQ
    } id_ex_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] result;
    } ex_mem_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] result;
    } mem_wb_t;

    localparam if_id_t  IF_ID_NOP  = '{valid: 1'b0, pc: 32'h0, instr: NOP_INSTR};
    localparam id_ex_t  ID_EX_NOP  = '0;
    localparam ex_mem_t EX_MEM_NOP = '0;
    localparam mem_wb_t MEM_WB_NOP = '0;

endpackage

// File: rtl/cpu_regfile.sv
// 32 x 32-bit register file, two combinational read ports, one write port.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset (clears all)
//   rs1_addr_i/rs2_addr_i read addresses
//   rs1_data_o/rs2_data_o read data; x0 always reads 0
//   wr_en_i, wr_addr_i,   write port; writes to x0 are dropped
//   wr_data_i
// A read of the register being written in the same cycle returns the new
// value, so a WB-stage producer is visible to the ID-stage consumer.
module cpu_regfile (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o,
    input  logic        wr_en_i,
    input  logic [4:0]  wr_addr_i,
    input  logic [31:0] wr_data_i
);

    logic [31:0] regs [32];
    logic        wr_live;

    assign wr_live = wr_en_i && (wr_addr_i != 5'd0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[wr_addr_i] <= wr_data_i;
        end
    end

    assign rs1_data_o = (rs1_addr_i == 5'd0)                   ? 32'h0 :
                        (wr_live && wr_addr_i == rs1_addr_i)   ? wr_data_i :
                                                                 regs[rs1_addr_i];
    assign rs2_data_o = (rs2_addr_i == 5'd0)                   ? 32'h0 :
                        (wr_live && wr_addr_i == rs2_addr_i)   ? wr_data_i :
                                                                 regs[rs2_addr_i];

endmodule

// File: rtl/cpu.sv
// Five-stage in-order core (IF/ID/EX/MEM/WB) for ADD, SUB, ADDI, BEQ, BNE.
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   wr_instr_en_i  append wr_instr_i to the instruction memory this cycle
//   wr_instr_i     instruction word to append
//   wb_valid_o     WB stage retires a register write this cycle
//   wb_rd_o        destination register of that write (0 when idle)
//   wb_data_o      value written (0 when idle)
//   pc_o           current fetch PC (byte address)
// Load port handshake: wr_instr_en_i is a valid-only strobe with no ready;
// every strobed word is accepted until IMEM_WORDS words are held, after
// which further words are silently dropped.
// Fetch stalls (pc holds, bubble inserted) while pc points at or past the
// last loaded word; a taken branch in EX overrides the stall.
module cpu
    import cpu_pkg::*;
#(
    parameter int IMEM_WORDS = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_instr_en_i,
    input  logic [31:0] wr_instr_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic [31:0] pc_o
);

    localparam int AW = $clog2(IMEM_WORDS);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] WPTR_FULL = PW'(IMEM_WORDS);

    // Instruction memory is not reset: a mid-run reset keeps the old words,
    // but wptr returns to 0 so they are never fetched before being reloaded.
    // That is why unwritten words are never observed as anything but NOP.
    logic [31:0]   imem [IMEM_WORDS];
    logic [PW-1:0] wptr;
    logic          wr_accept;

    logic [31:0] pc, pc_next;
    logic [31:0] fetch_word;
    logic        fetch_stall;

    if_id_t  if_id,  if_id_next;
    id_ex_t  id_ex,  id_ex_dec, id_ex_next;
    ex_mem_t ex_mem, ex_mem_next;
    mem_wb_t mem_wb, mem_wb_next;

    logic [31:0] rf_rs1, rf_rs2;

    // ---------------- load port ----------------
    assign wr_accept = wr_instr_en_i && (wptr != WPTR_FULL);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr <= '0;
        end else if (wr_accept) begin
            wptr <= wptr + PW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_accept) begin
            imem[wptr[AW-1:0]] <= wr_instr_i;
        end
    end

    // ---------------- fetch ----------------
    // The stall compare uses the pre-write wptr, so a word written this
    // cycle at the fetch index is picked up one cycle later.
    assign fetch_stall = ({2'b00, pc[31:2]} >= 32'(wptr));
    assign fetch_word  = imem[pc[AW+1:2]];

    // ---------------- decode ----------------
    logic [6:0] dec_opc;
    logic [2:0] dec_f3;
    logic [6:0] dec_f7;
    logic       dec_add, dec_sub, dec_addi, dec_beq, dec_bne;

    assign dec_opc  = if_id.instr[6:0];
    assign dec_f3   = if_id.instr[14:12];
    assign dec_f7   = if_id.instr[31:25];
    assign dec_add  = (dec_opc == OPC_OP)     && (dec_f3 == F3_ADD_SUB) && (dec_f7 == F7_ADD);
    assign dec_sub  = (dec_opc == OPC_OP)     && (dec_f3 == F3_ADD_SUB) && (dec_f7 == F7_SUB);
    assign dec_addi = (dec_opc == OPC_OP_IMM) && (dec_f3 == F3_ADDI);
    assign dec_beq  = (dec_opc == OPC_BRANCH) && (dec_f3 == F3_BEQ);
    assign dec_bne  = (dec_opc == OPC_BRANCH) && (dec_f3 == F3_BNE);

    cpu_regfile u_regfile (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rs1_addr_i (if_id.instr[19:15]),
        .rs2_addr_i (if_id.instr[24:20]),
        .rs1_data_o (rf_rs1),
        .rs2_data_o (rf_rs2),
        .wr_en_i    (wb_valid_o),
        .wr_addr_i  (mem_wb.rd),
        .wr_data_i  (mem_wb.result)
    );

    always_comb begin
        id_ex_dec           = ID_EX_NOP;
        id_ex_dec.valid     = if_id.valid;
        id_ex_dec.pc        = if_id.pc;
        id_ex_dec.instr     = if_id.instr;
        id_ex_dec.rd        = if_id.instr[11:7];
        id_ex_dec.rs1       = if_id.instr[19:15];
        id_ex_dec.rs2       = if_id.instr[24:20];
        id_ex_dec.rs1_val   = rf_rs1;
        id_ex_dec.rs2_val   = rf_rs2;
        // Writes to x0 are turned into non-writing ops here, so they never
        // forward and never show up on the WB port.
        id_ex_dec.we        = if_id.valid && (dec_add || dec_sub || dec_addi)
                              && (if_id.instr[11:7] != 5'd0);
        id_ex_dec.use_imm   = dec_addi;
        id_ex_dec.alu_op    = dec_sub ? ALU_SUB : ALU_ADD;
        id_ex_dec.is_branch = if_id.valid && (dec_beq || dec_bne);
        id_ex_dec.br_ne     = dec_bne;
        id_ex_dec.imm       = dec_addi
            ? {{20{if_id.instr[31]}}, if_id.instr[31:20]}
            : {{19{if_id.instr[31]}}, if_id.instr[31], if_id.instr[7],
               if_id.instr[30:25], if_id.instr[11:8], 1'b0};
    end

    // ---------------- execute ----------------
    logic [31:0] op_a, op_b, alu_b, alu_res, br_target;
    logic        br_taken;

    always_comb begin
        // Youngest producer wins: EX/MEM before MEM/WB before regfile value.
        op_a = id_ex.rs1_val;
        if (ex_mem.valid && ex_mem.we && ex_mem.rd != 5'd0 && ex_mem.rd == id_ex.rs1)
            op_a = ex_mem.result;
        else if (mem_wb.valid && mem_wb.we && mem_wb.rd != 5'd0 && mem_wb.rd == id_ex.rs1)
            op_a = mem_wb.result;

        op_b = id_ex.rs2_val;
        if (ex_mem.valid && ex_mem.we && ex_mem.rd != 5'd0 && ex_mem.rd == id_ex.rs2)
            op_b = ex_mem.result;
        else if (mem_wb.valid && mem_wb.we && mem_wb.rd != 5'd0 && mem_wb.rd == id_ex.rs2)
            op_b = mem_wb.result;

        alu_b     = id_ex.use_imm ? id_ex.imm : op_b;
        alu_res   = (id_ex.alu_op == ALU_SUB) ? (op_a - alu_b) : (op_a + alu_b);
        br_taken  = id_ex.valid && id_ex.is_branch &&
                    (id_ex.br_ne ? (op_a != op_b) : (op_a == op_b));
        br_target = id_ex.pc + id_ex.imm;

        ex_mem_next        = EX_MEM_NOP;
        ex_mem_next.valid  = id_ex.valid;
        ex_mem_next.pc     = id_ex.pc;
        ex_mem_next.instr  = id_ex.instr;
        ex_mem_next.we     = id_ex.we;
        ex_mem_next.rd     = id_ex.rd;
        ex_mem_next.result = alu_res;
    end

    // ---------------- memory (pass-through) ----------------
    always_comb begin
        mem_wb_next        = MEM_WB_NOP;
        mem_wb_next.valid  = ex_mem.valid;
        mem_wb_next.pc     = ex_mem.pc;
        mem_wb_next.instr  = ex_mem.instr;
        mem_wb_next.we     = ex_mem.we;
        mem_wb_next.rd     = ex_mem.rd;
        mem_wb_next.result = ex_mem.result;
    end

    // ---------------- pc / flush control ----------------
    always_comb begin
        pc_next    = pc + 32'd4;
        if_id_next = '{valid: 1'b1, pc: pc, instr: fetch_word};
        id_ex_next = id_ex_dec;
        if (br_taken) begin
            // The two younger instructions (in IF and ID) are squashed.
            pc_next    = br_target;
            if_id_next = IF_ID_NOP;
            id_ex_next = ID_EX_NOP;
        end else if (fetch_stall) begin
            pc_next    = pc;
            if_id_next = IF_ID_NOP;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc     <= '0;
            if_id  <= IF_ID_NOP;
            id_ex  <= ID_EX_NOP;
            ex_mem <= EX_MEM_NOP;
            mem_wb <= MEM_WB_NOP;
        end else begin
            pc     <= pc_next;
            if_id  <= if_id_next;
            id_ex  <= id_ex_next;
            ex_mem <= ex_mem_next;
            mem_wb <= mem_wb_next;
        end
    end

    // ---------------- outputs ----------------
    assign wb_valid_o = mem_wb.valid && mem_wb.we;
    assign wb_rd_o    = wb_valid_o ? mem_wb.rd     : 5'd0;
    assign wb_data_o  = wb_valid_o ? mem_wb.result : 32'h0;
    assign pc_o       = pc;

    // instr/pc are carried down the pipe purely for waveform debug.
    logic unused_debug;
    assign unused_debug = ^{id_ex.instr, ex_mem.pc, ex_mem.instr, mem_wb.pc, mem_wb.instr};

endmodule

// File: tb/tb_cpu.sv
module tb_cpu;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        wr_instr_en_i = 1'b0;
    logic [31:0] wr_instr_i = 32'h0;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic [31:0] pc_o;

    cpu #(.IMEM_WORDS(64)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .wr_instr_en_i (wr_instr_en_i),
        .wr_instr_i    (wr_instr_i),
        .wb_valid_o    (wb_valid_o),
        .wb_rd_o       (wb_rd_o),
        .wb_data_o     (wb_data_o),
        .pc_o          (pc_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [36:0] exp_q[$];      // {rd, data} in retirement order
    logic [31:0] prog_q[$];
    int          first_wr_cyc = -1;
    int          first_wb_cyc = -1;
    int          last_wb_cyc  = -1;
    int          bubbles      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk_i) begin
        logic [36:0] e;
        if (!rst_i && wb_valid_o) begin
            if (first_wb_cyc < 0) first_wb_cyc = cyc;
            if (last_wb_cyc >= 0) bubbles += cyc - last_wb_cyc - 1;
            last_wb_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("wb_unexpected", 32'(wb_valid_o), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wb_rd", 32'(wb_rd_o), 32'(e[36:32]));
                check("wb_data", wb_data_o, e[31:0]);
            end
        end
    end

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_addi(input int rd, input int rs1, input int imm);
        logic [31:0] i;
        i = imm;
        return {i[11:0], 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rd, input int rs1, input int rs2);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_b(input int f3, input int rs1, input int rs2, input int off);
        logic [12:0] o;
        o = 13'(off);
        return {o[12], o[10:5], 5'(rs2), 5'(rs1), 3'(f3), o[4:1], o[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] rand_instr();
        int          k, rd, rs1, rs2;
        logic [31:0] r;
        k   = $urandom_range(0, 9);
        r   = $urandom();
        rd  = $urandom_range(0, 7);
        rs1 = $urandom_range(0, 7);
        rs2 = $urandom_range(0, 7);
        case (k)
            0, 1, 2: return enc_addi(rd, rs1, int'(r[11:0]));
            3, 4:    return enc_r(7'h00, rd, rs1, rs2);
            5:       return enc_r(7'h20, rd, rs1, rs2);
            6:       return enc_b(0, rs1, rs2, 4 * $urandom_range(1, 4));
            7:       return enc_b(1, rs1, rs2, 4 * $urandom_range(1, 4));
            8:       return {r[31:7], 7'b0000011};           // unsupported opcode
            default: return enc_r(7'h01, rd, rs1, rs2);      // unsupported funct7
        endcase
    endfunction

    // ---------------- reference model: architectural ISS ----------------
    task automatic model_run(output logic [31:0] fpc);
        logic [31:0] r[32];
        logic [31:0] pc, pc_n, ins, a, b, imm_i, imm_b;
        int          n, steps;
        n = (prog_q.size() > 64) ? 64 : prog_q.size();
        for (int i = 0; i < 32; i++) r[i] = 32'h0;
        pc = 0;
        steps = 0;
        while ((pc >> 2) < 32'(n) && steps < 2000) begin
            ins   = prog_q[pc >> 2];
            a     = r[ins[19:15]];
            b     = r[ins[24:20]];
            imm_i = {{20{ins[31]}}, ins[31:20]};
            imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            pc_n  = pc + 4;
            if (ins[6:0] == 7'b0110011 && ins[14:12] == 3'b000 && ins[31:25] == 7'h00) begin
                if (ins[11:7] != 0) begin r[ins[11:7]] = a + b; exp_q.push_back({ins[11:7], a + b}); end
            end else if (ins[6:0] == 7'b0110011 && ins[14:12] == 3'b000 && ins[31:25] == 7'h20) begin
                if (ins[11:7] != 0) begin r[ins[11:7]] = a - b; exp_q.push_back({ins[11:7], a - b}); end
            end else if (ins[6:0] == 7'b0010011 && ins[14:12] == 3'b000) begin
                if (ins[11:7] != 0) begin r[ins[11:7]] = a + imm_i; exp_q.push_back({ins[11:7], a + imm_i}); end
            end else if (ins[6:0] == 7'b1100011 && ins[14:12] == 3'b000) begin
                if (a == b) pc_n = pc + imm_b;
            end else if (ins[6:0] == 7'b1100011 && ins[14:12] == 3'b001) begin
                if (a != b) pc_n = pc + imm_b;
            end
            pc = pc_n;
            steps++;
        end
        fpc = pc;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        exp_q.delete();
        first_wr_cyc = -1;
        first_wb_cyc = -1;
        last_wb_cyc  = -1;
        bubbles      = 0;
        @(negedge clk_i);
        @(negedge clk_i);
        #2 rst_i = 1'b0;
    endtask

    task automatic push_exp(input int rd, input logic [31:0] v);
        exp_q.push_back({5'(rd), v});
    endtask

    task automatic load_prog(input bit rand_gaps, input int pause_after, input int pause_len);
        for (int k = 0; k < prog_q.size(); k++) begin
            if (k == pause_after) begin
                for (int g = 0; g < pause_len; g++) begin
                    @(negedge clk_i);
                    wr_instr_en_i = 1'b0;
                    if (g >= 1) check("pause_pc_hold", pc_o, 32'(4 * pause_after));
                end
            end else if (rand_gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk_i);
                    wr_instr_en_i = 1'b0;
                end
            end
            @(negedge clk_i);
            wr_instr_en_i = 1'b1;
            wr_instr_i    = prog_q[k];
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
        end
        @(negedge clk_i);
        wr_instr_en_i = 1'b0;
    endtask

    task automatic drain(input logic [31:0] final_pc);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk_i);
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (8) @(negedge clk_i);
        check("final_pc", pc_o, final_pc);
    endtask

    task automatic set_branch_prog();
        // Branch offset +12 skips both ADDI 28 words and lands on the ADD.
        prog_q = '{enc_addi(1, 0, 30), enc_addi(2, 0, 30), enc_b(0, 1, 2, 12),
                   enc_addi(1, 0, 28), enc_addi(2, 0, 28), enc_r(7'h00, 6, 3, 3)};
        push_exp(1, 30);
        push_exp(2, 30);
        push_exp(6, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] fpc;
        int          n;

        repeat (2) @(negedge clk_i);
        check("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        check("rst_wb_rd",    32'(wb_rd_o),    32'd0);
        check("rst_wb_data",  wb_data_o,       32'd0);
        check("rst_pc",       pc_o,            32'd0);

        // Forwarded BEQ taken; flushed ADDIs must not retire.
        do_reset();
        set_branch_prog();
        load_prog(1'b0, -1, 0);
        drain(32'd24);

        // Back-to-back dependencies through EX/MEM and MEM/WB.
        do_reset();
        prog_q = '{enc_addi(1, 0, 5), enc_r(7'h00, 2, 1, 1), enc_r(7'h00, 3, 2, 1)};
        push_exp(1, 5); push_exp(2, 10); push_exp(3, 15);
        load_prog(1'b0, -1, 0);
        drain(32'd12);

        // BNE not taken.
        do_reset();
        prog_q = '{enc_b(1, 0, 0, 8), enc_addi(4, 0, 7)};
        push_exp(4, 7);
        load_prog(1'b0, -1, 0);
        drain(32'd8);

        // x0 immutability and wrap-around.
        do_reset();
        prog_q = '{enc_addi(0, 0, 9), enc_r(7'h00, 7, 0, 0), enc_addi(5, 0, -1), enc_addi(5, 5, 1)};
        push_exp(7, 0); push_exp(5, 32'hffff_ffff); push_exp(5, 0);
        load_prog(1'b0, -1, 0);
        drain(32'd16);

        // Streaming latency and a 3-cycle load pause.
        do_reset();
        prog_q = '{enc_addi(1, 0, 5), enc_r(7'h00, 2, 1, 1), enc_r(7'h00, 3, 2, 1),
                   enc_addi(4, 3, 1), enc_addi(5, 4, 1), enc_addi(6, 5, 1)};
        push_exp(1, 5); push_exp(2, 10); push_exp(3, 15);
        push_exp(4, 16); push_exp(5, 17); push_exp(6, 18);
        load_prog(1'b0, 3, 3);
        drain(32'd24);
        check("first_wb_latency", 32'(first_wb_cyc - first_wr_cyc), 32'd5);
        check("pause_bubbles", 32'(bubbles), 32'd3);

        // Mid-run reset then reload.
        do_reset();
        set_branch_prog();
        load_prog(1'b0, -1, 0);
        n = 0;
        while (!wb_valid_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check("midrst_busy_before", 32'(wb_valid_o), 32'd1);
        #2 rst_i = 1'b1;
        #1;
        check("midrst_wb_valid", 32'(wb_valid_o), 32'd0);
        check("midrst_wb_rd",    32'(wb_rd_o),    32'd0);
        check("midrst_wb_data",  wb_data_o,       32'd0);
        check("midrst_pc",       pc_o,            32'd0);
        exp_q.delete();
        first_wr_cyc = -1; first_wb_cyc = -1; last_wb_cyc = -1; bubbles = 0;
        @(negedge clk_i);
        #2 rst_i = 1'b0;
        set_branch_prog();
        load_prog(1'b0, -1, 0);
        drain(32'd24);

        // Load past capacity: only the first 64 words are kept.
        do_reset();
        prog_q.delete();
        for (int k = 0; k < 66; k++) prog_q.push_back(enc_addi(1, 1, 1));
        model_run(fpc);
        load_prog(1'b0, -1, 0);
        drain(fpc);

        // Randomized programs with random load gaps.
        for (int t = 0; t < 8; t++) begin
            do_reset();
            prog_q.delete();
            n = $urandom_range(10, 24);
            for (int k = 0; k < n; k++) prog_q.push_back(rand_instr());
            model_run(fpc);
            load_prog(1'b1, -1, 0);
            drain(fpc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
